// File: rtl/display_digit_scanner.sv
// Multiplexed 7-segment digit scanner: one shared decoder, one-hot digit enables,
// a blanking gap between slots, and frame-aligned double buffering of the displayed value.
module display_digit_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic                    lz_blank_en,
    output logic [3:0]              data,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SHOW_CYCLES = REFRESH_DIV - BLANK_CYCLES;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    localparam logic [3:0]              CODE_BLANK = 4'hF;
    localparam logic [IDX_W-1:0]        IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]        BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]        SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0]   EN_ONE     = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
    localparam logic [4*NUM_DIGITS-1:0] ALL_BLANK  = {NUM_DIGITS{4'hF}};

    logic [0:0]              state_r;
    logic [IDX_W-1:0]        idx_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [4*NUM_DIGITS-1:0] shadow_r;
    logic [4*NUM_DIGITS-1:0] pending_r;
    logic                    pending_valid_r;

    logic [0:0]              state_s;
    logic [IDX_W-1:0]        idx_s;
    logic [CNT_W-1:0]        cnt_s;
    logic                    wrap_s;
    logic [NUM_DIGITS-1:0]   lz_mask_s;
    logic [3:0]              code_s;

    // Bit i set when digit i sits inside the run of leading zeros; digit 0 always shows.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] s);
        logic [NUM_DIGITS-1:0] m;
        logic                  run;
        m   = '0;
        run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run  = run & (s[4*i +: 4] == 4'h0);
            m[i] = run;
        end
        return m;
    endfunction

    // Slot sequencing: blank gap, then show, advancing the digit index at slot end.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r + CNT_W'(1);
        wrap_s  = 1'b0;
        case (state_r)
            ST_BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    state_s = ST_SHOW;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_BLANK;
                end
            end
            ST_SHOW: begin
                if (cnt_r == SHOW_LAST) begin
                    state_s = ST_BLANK;
                    cnt_s   = '0;
                    if (idx_r == IDX_LAST) begin
                        idx_s  = '0;
                        wrap_s = 1'b1;
                    end else begin
                        idx_s  = idx_r + IDX_W'(1);
                    end
                end else begin
                    state_s = ST_SHOW;
                end
            end
            default: begin
                state_s = ST_BLANK;
                idx_s   = '0;
                cnt_s   = '0;
            end
        endcase
    end

    // Code for the digit being shown; lz_blank_en is used live every show cycle.
    always_comb begin
        lz_mask_s = lz_mask(shadow_r);
        if (lz_blank_en && lz_mask_s[idx_r]) begin
            code_s = CODE_BLANK;
        end else begin
            code_s = shadow_r[{idx_r, 2'b00} +: 4];
        end
    end

    // State, buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r         <= ST_BLANK;
            idx_r           <= '0;
            cnt_r           <= '0;
            shadow_r        <= ALL_BLANK;
            pending_r       <= ALL_BLANK;
            pending_valid_r <= 1'b0;
            data            <= CODE_BLANK;
            digit_en        <= '0;
            frame_done      <= 1'b0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            cnt_r      <= cnt_s;
            frame_done <= wrap_s;
            // Entering or staying in SHOW never changes idx, so idx_r selects the digit.
            if (state_s == ST_SHOW) begin
                data     <= code_s;
                digit_en <= EN_ONE << idx_r;
            end else begin
                data     <= CODE_BLANK;
                digit_en <= '0;
            end
            if (wrap_s && pending_valid_r) begin
                shadow_r <= pending_r;
            end
            // A load on the wrap edge keeps its value pending for the next frame.
            if (load) begin
                pending_r       <= digits_in;
                pending_valid_r <= 1'b1;
            end else if (wrap_s) begin
                pending_valid_r <= 1'b0;
            end
        end
    end

endmodule
